alu_issue_ctrl: RTL and testbench

Multi-cycle issue/writeback controller that drives the team's 32-bit ALU (operands A, B and 4-bit ALUOp in; Result and Zero out). Accepts one RV32I integer register-register or register-immediate instruction per handshake, decodes it to an ALUOp, reads operands from the synchronous-read register file, presents them to the ALU, and writes the ALU result back. Sits between instruction fetch and the register file/ALU pair in the lab datapath.

---
 rtl/alu_issue_ctrl_if.sv | 34 +++
 rtl/alu_issue_ctrl.sv | 171 +++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_ctrl_if.sv
// Bundle between the issue controller and its fetch, register-file and ALU neighbours.
// The master side is the controller; the slave side is the surrounding datapath.
interface alu_issue_ctrl_if;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_op;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        rd_we;
  logic [4:0]  rd_addr;
  logic [31:0] rd_wdata;
  logic        illegal;
  logic        last_zero;
  logic [31:0] retired;

  modport master (
    input  instr_valid, instr, rs1_data, rs2_data, alu_result, alu_zero,
    output instr_ready, rs1_addr, rs2_addr, alu_a, alu_b, alu_op,
           rd_we, rd_addr, rd_wdata, illegal, last_zero, retired
  );

  modport slave (
    output instr_valid, instr, rs1_data, rs2_data, alu_result, alu_zero,
    input  instr_ready, rs1_addr, rs2_addr, alu_a, alu_b, alu_op,
           rd_we, rd_addr, rd_wdata, illegal, last_zero, retired
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Four-state issue/writeback controller for RV32I ALU register-register and
// register-immediate instructions: decode at accept, read, execute, write back.
//
// state | meaning
// IDLE  | waiting for an instruction; instr_ready high
// READ  | register-file addresses presented; illegal pulse if unsupported
// EXEC  | operands and ALUOp registered toward the ALU
// WB    | ALU result written back (rd_we unless rd is x0)
module alu_issue_ctrl (
  input  logic             clk,
  input  logic             rst_n,
  alu_issue_ctrl_if.master bus
);
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_SLL = 4'b0101;
  localparam logic [3:0] OP_SRL = 4'b0110;
  localparam logic [3:0] OP_SRA = 4'b0111;

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  state_t      r_state;
  logic [4:0]  r_rs1_addr;
  logic [4:0]  r_rs2_addr;
  logic [4:0]  r_rd;
  logic [31:0] r_imm;
  logic        r_use_imm;
  logic [3:0]  r_op_dec;
  logic        r_illegal;
  logic [31:0] r_alu_a;
  logic [31:0] r_alu_b;
  logic [3:0]  r_alu_op;
  logic        r_rd_we;
  logic [4:0]  r_rd_addr;
  logic        r_last_zero;
  logic [31:0] r_retired;

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic        w_f7_std;
  logic        w_f7_alt;
  logic [3:0]  w_dec_op;
  logic        w_dec_ill;
  logic [31:0] w_dec_imm;
  logic        w_dec_use_imm;

  assign w_opcode = bus.instr[6:0];
  assign w_funct3 = bus.instr[14:12];
  assign w_funct7 = bus.instr[31:25];
  assign w_f7_std = (w_funct7 == 7'b0000000);
  assign w_f7_alt = (w_funct7 == 7'b0100000);

  always_comb begin
    w_dec_op      = OP_ADD;
    w_dec_ill     = 1'b0;
    w_dec_imm     = {{20{bus.instr[31]}}, bus.instr[31:20]};
    w_dec_use_imm = 1'b0;
    case (w_opcode)
      7'b0110011: begin
        case (w_funct3)
          3'b000: begin
            w_dec_op  = w_f7_alt ? OP_SUB : OP_ADD;
            w_dec_ill = !(w_f7_std || w_f7_alt);
          end
          3'b111: begin w_dec_op = OP_AND; w_dec_ill = !w_f7_std; end
          3'b110: begin w_dec_op = OP_OR;  w_dec_ill = !w_f7_std; end
          3'b100: begin w_dec_op = OP_XOR; w_dec_ill = !w_f7_std; end
          3'b001: begin w_dec_op = OP_SLL; w_dec_ill = !w_f7_std; end
          3'b101: begin
            w_dec_op  = w_f7_alt ? OP_SRA : OP_SRL;
            w_dec_ill = !(w_f7_std || w_f7_alt);
          end
          default: w_dec_ill = 1'b1;
        endcase
      end
      7'b0010011: begin
        w_dec_use_imm = 1'b1;
        case (w_funct3)
          3'b000: w_dec_op = OP_ADD;
          3'b111: w_dec_op = OP_AND;
          3'b110: w_dec_op = OP_OR;
          3'b100: w_dec_op = OP_XOR;
          3'b001: begin
            w_dec_op  = OP_SLL;
            w_dec_ill = !w_f7_std;
            w_dec_imm = {27'b0, bus.instr[24:20]};
          end
          3'b101: begin
            w_dec_op  = w_f7_alt ? OP_SRA : OP_SRL;
            w_dec_ill = !(w_f7_std || w_f7_alt);
            w_dec_imm = {27'b0, bus.instr[24:20]};
          end
          default: w_dec_ill = 1'b1;
        endcase
      end
      default: w_dec_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_rs1_addr  <= '0;
      r_rs2_addr  <= '0;
      r_rd        <= '0;
      r_imm       <= '0;
      r_use_imm   <= 1'b0;
      r_op_dec    <= OP_ADD;
      r_illegal   <= 1'b0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_op    <= OP_ADD;
      r_rd_we     <= 1'b0;
      r_rd_addr   <= '0;
      r_last_zero <= 1'b0;
      r_retired   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.instr_valid) begin
            r_rs1_addr <= bus.instr[19:15];
            r_rs2_addr <= bus.instr[24:20];
            r_rd       <= bus.instr[11:7];
            r_imm      <= w_dec_imm;
            r_use_imm  <= w_dec_use_imm;
            r_op_dec   <= w_dec_op;
            r_illegal  <= w_dec_ill;
            r_state    <= READ;
          end
        end
        READ: begin
          r_illegal <= 1'b0;
          r_state   <= r_illegal ? IDLE : EXEC;
        end
        EXEC: begin
          r_alu_a   <= bus.rs1_data;
          r_alu_b   <= r_use_imm ? r_imm : bus.rs2_data;
          r_alu_op  <= r_op_dec;
          r_rd_we   <= (r_rd != 5'd0);
          r_rd_addr <= r_rd;
          r_state   <= WB;
        end
        WB: begin
          r_rd_we     <= 1'b0;
          r_last_zero <= bus.alu_zero;
          r_retired   <= r_retired + 32'd1;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Pulsed/strobe outputs are masked by rst_n so a reset mid-instruction shows nothing.
  assign bus.instr_ready = (r_state == IDLE) && rst_n;
  assign bus.rd_we       = r_rd_we && rst_n;
  assign bus.illegal     = r_illegal && rst_n;
  assign bus.rd_wdata    = ((r_state == WB) && rst_n) ? bus.alu_result : 32'd0;
  assign bus.rs1_addr    = r_rs1_addr;
  assign bus.rs2_addr    = r_rs2_addr;
  assign bus.alu_a       = r_alu_a;
  assign bus.alu_b       = r_alu_b;
  assign bus.alu_op      = r_alu_op;
  assign bus.rd_addr     = r_rd_addr;
  assign bus.last_zero   = r_last_zero;
  assign bus.retired     = r_retired;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: register file and ALU models around the DUT, with an
// instruction-level reference that computes each writeback from RV32I semantics.
module tb_alu_issue_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_issue_ctrl_if bus();
  alu_issue_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_checks = 0;
  int n_errors = 0;

  // Synchronous-read register file with a bench-side preload port.
  logic [31:0] rf [32];
  logic        pl_en;
  logic [4:0]  pl_addr;
  logic [31:0] pl_data;
  logic        rf_clr;

  always @(posedge clk) begin
    bus.rs1_data <= rf[bus.rs1_addr];
    bus.rs2_data <= rf[bus.rs2_addr];
    if (rf_clr) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
    end else if (pl_en) begin
      if (pl_addr != 5'd0) rf[pl_addr] <= pl_data;
    end else if (bus.rd_we && bus.rd_addr != 5'd0) begin
      rf[bus.rd_addr] <= bus.rd_wdata;
    end
  end

  always_comb begin
    case (bus.alu_op)
      4'd0: bus.alu_result = bus.alu_a + bus.alu_b;
      4'd1: bus.alu_result = bus.alu_a - bus.alu_b;
      4'd2: bus.alu_result = bus.alu_a & bus.alu_b;
      4'd3: bus.alu_result = bus.alu_a | bus.alu_b;
      4'd4: bus.alu_result = bus.alu_a ^ bus.alu_b;
      4'd5: bus.alu_result = bus.alu_a << bus.alu_b[4:0];
      4'd6: bus.alu_result = bus.alu_a >> bus.alu_b[4:0];
      4'd7: bus.alu_result = 32'($signed(bus.alu_a) >>> bus.alu_b[4:0]);
      default: bus.alu_result = 32'd0;
    endcase
    bus.alu_zero = (bus.alu_result == 32'd0);
  end

  // Reference state: architectural registers, retire count, last zero flag.
  logic [31:0] ref_rf [32];
  logic [31:0] exp_ret;
  logic        exp_lz;

  typedef struct {
    logic        legal;
    logic [4:0]  rd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] val;
    logic [3:0]  op;
  } exp_t;

  function automatic exp_t ref_exec(input logic [31:0] ins);
    exp_t e;
    logic [6:0] opc;
    logic [6:0] f7;
    logic [2:0] f3;
    logic is_r, is_i, std7, alt7;
    opc  = ins[6:0];
    f7   = ins[31:25];
    f3   = ins[14:12];
    is_r = (opc == 7'h33);
    is_i = (opc == 7'h13);
    std7 = (f7 == 7'h00);
    alt7 = (f7 == 7'h20);
    e.rd = ins[11:7];
    e.a  = ref_rf[ins[19:15]];
    if (is_r) e.b = ref_rf[ins[24:20]];
    else if (f3 == 3'd1 || f3 == 3'd5) e.b = {27'b0, ins[24:20]};
    else e.b = {{20{ins[31]}}, ins[31:20]};
    e.legal = 1'b0;
    e.op    = 4'd0;
    e.val   = 32'd0;
    if (is_r || is_i) begin
      case (f3)
        3'd0: if (is_i || std7) begin e.legal = 1'b1; e.op = 4'd0; e.val = e.a + e.b; end
              else if (alt7) begin e.legal = 1'b1; e.op = 4'd1; e.val = e.a - e.b; end
        3'd7: begin e.legal = is_i || std7; e.op = 4'd2; e.val = e.a & e.b; end
        3'd6: begin e.legal = is_i || std7; e.op = 4'd3; e.val = e.a | e.b; end
        3'd4: begin e.legal = is_i || std7; e.op = 4'd4; e.val = e.a ^ e.b; end
        3'd1: begin e.legal = std7; e.op = 4'd5; e.val = e.a << e.b[4:0]; end
        3'd5: if (std7) begin e.legal = 1'b1; e.op = 4'd6; e.val = e.a >> e.b[4:0]; end
              else if (alt7) begin e.legal = 1'b1; e.op = 4'd7; e.val = 32'($signed(e.a) >>> e.b[4:0]); end
        default: e.legal = 1'b0;
      endcase
    end
    return e;
  endfunction

  function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] itype(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_reg(input logic [4:0] idx, input logic [31:0] val);
    pl_en   = 1'b1;
    pl_addr = idx;
    pl_data = val;
    @(negedge clk);
    pl_en = 1'b0;
    if (idx != 5'd0) ref_rf[idx] = val;
  endtask

  task automatic wait_ready();
    for (int w = 0; w < 20 && !bus.instr_ready; w++) @(negedge clk);
    chk("ready_wait", 32'(bus.instr_ready), 32'd1);
  endtask

  // One instruction with cycle-exact checks; instr_valid is held with junk while busy.
  task automatic run_one(input logic [31:0] ins);
    exp_t e;
    e = ref_exec(ins);
    wait_ready();
    bus.instr       = ins;
    bus.instr_valid = 1'b1;
    @(negedge clk);
    bus.instr = $urandom();
    chk("illegal_t1", 32'(bus.illegal), 32'(!e.legal));
    chk("ready_t1", 32'(bus.instr_ready), 32'd0);
    @(negedge clk);
    if (!e.legal) begin
      bus.instr_valid = 1'b0;
      chk("ready_t2_ill", 32'(bus.instr_ready), 32'd1);
      chk("illegal_t2", 32'(bus.illegal), 32'd0);
      chk("rd_we_ill", 32'(bus.rd_we), 32'd0);
      chk("retired_ill", bus.retired, exp_ret);
      return;
    end
    chk("rd_we_t2", 32'(bus.rd_we), 32'd0);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    chk("rd_we_t3", 32'(bus.rd_we), 32'(e.rd != 5'd0));
    chk("rd_addr", 32'(bus.rd_addr), 32'(e.rd));
    chk("rd_wdata", bus.rd_wdata, e.val);
    chk("alu_op", 32'(bus.alu_op), 32'(e.op));
    chk("alu_a", bus.alu_a, e.a);
    chk("alu_b", bus.alu_b, e.b);
    if (e.rd != 5'd0) ref_rf[e.rd] = e.val;
    exp_ret = exp_ret + 32'd1;
    exp_lz  = (e.val == 32'd0);
    @(negedge clk);
    chk("ready_t4", 32'(bus.instr_ready), 32'd1);
    chk("rd_we_t4", 32'(bus.rd_we), 32'd0);
    chk("retired", bus.retired, exp_ret);
    chk("last_zero", 32'(bus.last_zero), 32'(exp_lz));
  endtask

  // Three legal instructions with instr_valid held high throughout.
  task automatic run_stream(input logic [31:0] i0, input logic [31:0] i1, input logic [31:0] i2);
    logic [31:0] ins [3];
    exp_t e [3];
    int acc [3];
    int idx, wbn;
    logic prev_ready;
    ins[0] = i0; ins[1] = i1; ins[2] = i2;
    for (int i = 0; i < 3; i++) begin
      e[i] = ref_exec(ins[i]);
      if (e[i].rd != 5'd0) ref_rf[e[i].rd] = e[i].val;
      acc[i] = 0;
    end
    wait_ready();
    idx = 0;
    wbn = 0;
    bus.instr       = ins[0];
    bus.instr_valid = 1'b1;
    prev_ready      = bus.instr_ready;
    for (int c = 1; c <= 40 && wbn < 3; c++) begin
      @(negedge clk);
      if (prev_ready && idx < 3) begin
        acc[idx] = c;
        idx++;
        if (idx < 3) bus.instr = ins[idx];
        else bus.instr_valid = 1'b0;
      end
      if (bus.rd_we) begin
        if (wbn < 3) begin
          chk("stream_rd_addr", 32'(bus.rd_addr), 32'(e[wbn].rd));
          chk("stream_rd_wdata", bus.rd_wdata, e[wbn].val);
        end
        wbn++;
      end
      prev_ready = bus.instr_ready;
    end
    bus.instr_valid = 1'b0;
    chk("stream_wb_count", 32'(wbn), 32'd3);
    chk("stream_gap1", 32'(acc[1] - acc[0]), 32'd4);
    chk("stream_gap2", 32'(acc[2] - acc[1]), 32'd4);
    exp_ret = exp_ret + 32'd3;
    exp_lz  = (e[2].val == 32'd0);
  endtask

  task automatic run_reset_in_exec();
    logic [31:0] ins;
    set_reg(5'd12, 32'd3);
    set_reg(5'd13, 32'd4);
    ins = rtype(7'h00, 5'd13, 5'd12, 3'd0, 5'd11);
    wait_ready();
    bus.instr       = ins;
    bus.instr_valid = 1'b1;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_rd_we", 32'(bus.rd_we), 32'd0);
    chk("rst_ready", 32'(bus.instr_ready), 32'd0);
    chk("rst_illegal", 32'(bus.illegal), 32'd0);
    chk("rst_retired", bus.retired, 32'd0);
    chk("rst_last_zero", 32'(bus.last_zero), 32'd0);
    chk("rst_alu_a", bus.alu_a, 32'd0);
    chk("rst_alu_b", bus.alu_b, 32'd0);
    chk("rst_alu_op", 32'(bus.alu_op), 32'd0);
    chk("rst_rs1_addr", 32'(bus.rs1_addr), 32'd0);
    chk("rst_rd_addr", 32'(bus.rd_addr), 32'd0);
    chk("rst_rd_wdata", bus.rd_wdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_ret = 32'd0;
    exp_lz  = 1'b0;
    chk("rst_no_write", rf[11], ref_rf[11]);
    run_one(ins);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ins;
    logic [6:0]  f7;
    logic [11:0] imm;
    int k;
    rst_n           = 1'b0;
    rf_clr          = 1'b1;
    pl_en           = 1'b0;
    pl_addr         = 5'd0;
    pl_data         = 32'd0;
    bus.instr_valid = 1'b0;
    bus.instr       = 32'd0;
    for (int i = 0; i < 32; i++) ref_rf[i] = 32'd0;
    exp_ret = 32'd0;
    exp_lz  = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ready", 32'(bus.instr_ready), 32'd0);
    chk("reset_rd_we", 32'(bus.rd_we), 32'd0);
    chk("reset_illegal", 32'(bus.illegal), 32'd0);
    chk("reset_retired", bus.retired, 32'd0);
    chk("reset_alu_op", 32'(bus.alu_op), 32'd0);
    chk("reset_last_zero", 32'(bus.last_zero), 32'd0);
    rf_clr = 1'b0;
    rst_n  = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 32'(bus.instr_ready), 32'd1);

    set_reg(5'd1, 32'd5);
    set_reg(5'd2, 32'd7);
    run_one(rtype(7'h00, 5'd2, 5'd1, 3'd0, 5'd3));
    set_reg(5'd1, 32'h1234);
    run_one(rtype(7'h20, 5'd1, 5'd1, 3'd0, 5'd4));
    set_reg(5'd6, 32'h8000_0000);
    run_one(itype(12'h404, 5'd6, 3'd5, 5'd5));
    run_one(itype(12'hFFF, 5'd0, 3'd0, 5'd7));
    run_one(itype(12'h001, 5'd1, 3'd0, 5'd0));
    run_one(rtype(7'h00, 5'd3, 5'd2, 3'd2, 5'd1));
    run_one({12'h000, 5'd1, 3'd2, 5'd2, 7'b0000011});
    run_stream(rtype(7'h00, 5'd2, 5'd1, 3'd0, 5'd8),
               rtype(7'h20, 5'd1, 5'd8, 3'd0, 5'd9),
               rtype(7'h00, 5'd2, 5'd9, 3'd4, 5'd10));
    run_reset_in_exec();

    for (int i = 1; i < 32; i++) set_reg(5'(i), $urandom());
    set_reg(5'd14, 32'h8000_0000);
    set_reg(5'd15, 32'd0);
    for (int n = 0; n < 60; n++) begin
      k = int'($urandom_range(0, 9));
      case ($urandom_range(0, 3))
        0: f7 = 7'h20;
        1: f7 = 7'($urandom());
        default: f7 = 7'h00;
      endcase
      if (k < 5) begin
        ins = rtype(f7, 5'($urandom()), 5'($urandom()), 3'($urandom()), 5'($urandom()));
      end else if (k < 9) begin
        imm = 12'($urandom());
        if ($urandom_range(0, 1) == 1) imm[11:5] = f7;
        ins = itype(imm, 5'($urandom()), 3'($urandom()), 5'($urandom()));
      end else begin
        ins = $urandom();
      end
      run_one(ins);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
